// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: byte-wide program memory read port plus the instruction
// queue head presented to the control unit and the PC redirect input.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_take;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_addr, mem_rd, instr, instr_valid, instr_pc,
    input  mem_rdata, mem_ack, pc_load, pc_in, instr_take
  );

  modport slave (
    input  mem_addr, mem_rd, instr, instr_valid, instr_pc,
    output mem_rdata, mem_ack, pc_load, pc_in, instr_take
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: assembles big-endian 16-bit words from a byte-wide memory
// into a DEPTH-entry prefetch queue; pc_load flushes and redirects.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           r,
  instr_fetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HI    = 2'd1;
  localparam logic [1:0] LO    = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [7:0]        hi_byte;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;

  logic [15:0]       q_word [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;

  logic              do_take, do_push, room_after;
  logic [PW:0]       count_nxt;
  logic [ADDR_W-1:0] target, ptr_inc;

  // A redirect overrides both the take and the push of the same cycle.
  assign do_take    = bus.instr_take && (count != '0) && !bus.pc_load;
  assign do_push    = (state == LO) && bus.mem_ack && !bus.pc_load;
  assign count_nxt  = count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_take};
  assign room_after = count_nxt < DEPTH_C;
  assign target     = bus.pc_in & ~ADDR_W'(1);
  assign ptr_inc    = fetch_ptr + ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (r) begin
      state     <= IDLE;
      fetch_ptr <= '0;
      hi_byte   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (bus.pc_load) begin
      fetch_ptr <= target;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      // An outstanding read must finish at its old address before redirecting.
      if (state == IDLE || bus.mem_ack) begin
        state   <= HI;
        rd_req  <= 1'b1;
        rd_addr <= target;
      end else begin
        state   <= DRAIN;
      end
    end else begin
      count <= count_nxt;
      if (do_take) rd_ptr <= rd_ptr + PW'(1);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      case (state)
        IDLE: if (count < DEPTH_C) begin
          state   <= HI;
          rd_req  <= 1'b1;
          rd_addr <= fetch_ptr;
        end
        HI: if (bus.mem_ack) begin
          hi_byte <= bus.mem_rdata;
          rd_addr <= fetch_ptr + ADDR_W'(1);
          state   <= LO;
        end
        LO: if (bus.mem_ack) begin
          fetch_ptr <= ptr_inc;
          if (room_after) begin
            state   <= HI;
            rd_addr <= ptr_inc;
          end else begin
            state   <= IDLE;
            rd_req  <= 1'b0;
          end
        end
        default: if (bus.mem_ack) begin
          state   <= HI;
          rd_addr <= fetch_ptr;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!r && do_push) begin
      q_word[wr_ptr] <= {hi_byte, bus.mem_rdata};
      q_pc[wr_ptr]   <= fetch_ptr;
    end
  end

  assign bus.mem_rd      = rd_req;
  assign bus.mem_addr    = rd_addr;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = (count != '0) ? q_word[rd_ptr] : 16'h0000;
  assign bus.instr_pc    = (count != '0) ? q_pc[rd_ptr] : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a
// queue-based transaction model, with a wait-state memory responder.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam int K_HI = 0, K_LO = 1, K_DROP = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(16)) intf ();
  instr_fetch #(.ADDR_W(16), .DEPTH(DEPTH)) dut (.clk(clk), .r(rst), .bus(intf));

  // Memory: ack once the request has been held for cur_wait cycles.
  logic [7:0] mem [65536];
  int wcnt, cur_wait, wmin, wmax;
  always @(posedge clk) begin
    if (rst) begin
      wcnt     <= 0;
      cur_wait <= int'($urandom_range(wmax, wmin));
    end else if (intf.mem_rd && intf.mem_ack) begin
      wcnt     <= 0;
      cur_wait <= int'($urandom_range(wmax, wmin));
    end else if (intf.mem_rd) begin
      wcnt <= wcnt + 1;
    end
  end
  assign intf.mem_ack   = intf.mem_rd && (wcnt >= cur_wait);
  assign intf.mem_rdata = mem[intf.mem_addr];

  // Reference model: one outstanding byte read plus a word queue.
  logic        m_rd;
  logic [15:0] m_addr, m_ptr;
  logic [7:0]  m_hi;
  int          m_kind;
  ent_t        mq [$];

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input logic rr, input logic pl, input logic [15:0] pi,
                            input logic tk, input logic ak, input logic [7:0] rb);
    int cnt0;
    if (rr) begin
      m_rd = 1'b0; m_addr = '0; m_ptr = '0; m_kind = K_HI; mq.delete();
    end else if (pl) begin
      mq.delete();
      m_ptr = {pi[15:1], 1'b0};
      if (!m_rd || ak) begin
        m_rd = 1'b1; m_addr = m_ptr; m_kind = K_HI;
      end else begin
        m_kind = K_DROP;
      end
    end else begin
      cnt0 = mq.size();
      if (tk && cnt0 > 0) void'(mq.pop_front());
      if (!m_rd) begin
        if (cnt0 < DEPTH) begin
          m_rd = 1'b1; m_addr = m_ptr; m_kind = K_HI;
        end
      end else if (ak) begin
        if (m_kind == K_HI) begin
          m_hi = rb; m_addr = m_ptr + 16'd1; m_kind = K_LO;
        end else if (m_kind == K_LO) begin
          mq.push_back(ent_t'{pc: m_ptr, word: {m_hi, rb}});
          m_ptr = m_ptr + 16'd2;
          if (mq.size() < DEPTH) begin
            m_addr = m_ptr; m_kind = K_HI;
          end else begin
            m_rd = 1'b0;
          end
        end else begin
          m_addr = m_ptr; m_kind = K_HI;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] e_instr, e_pc;
    e_instr = (mq.size() > 0) ? mq[0].word : 16'h0000;
    e_pc    = (mq.size() > 0) ? mq[0].pc   : 16'h0000;
    chk("instr_valid", 32'(intf.instr_valid), 32'(mq.size() > 0));
    chk("instr", 32'(intf.instr), 32'(e_instr));
    chk("instr_pc", 32'(intf.instr_pc), 32'(e_pc));
    chk("mem_rd", 32'(intf.mem_rd), 32'(m_rd));
    if (m_rd) chk("mem_addr", 32'(intf.mem_addr), 32'(m_addr));
  endtask

  // One clock cycle: drive inputs, advance model, observe after the edge.
  task automatic step(input logic rr, input logic pl, input logic [15:0] pi, input logic tk);
    rst = rr; intf.pc_load = pl; intf.pc_in = pi; intf.instr_take = tk;
    #1;
    model_step(rr, pl, pi, tk, intf.mem_ack, intf.mem_rdata);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n, input logic tk);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, tk);
  endtask

  task automatic do_reset(input int w);
    wmin = w; wmax = w;
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic wait_valid(input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (intf.instr_valid) ok = 1'b1;
      else run(1, 1'b0);
    end
    if (!ok) ok = intf.instr_valid;
    chk("wait_valid_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    rst = 1'b1; intf.pc_load = 1'b0; intf.pc_in = '0; intf.instr_take = 1'b0;
    wmin = 0; wmax = 0;
    @(negedge clk);

    // Reset and cold fetch, zero-wait
    do_reset(0);
    chk("rst_valid", 32'(intf.instr_valid), 32'd0);
    chk("rst_instr", 32'(intf.instr), 32'd0);
    chk("rst_pc", 32'(intf.instr_pc), 32'd0);
    chk("rst_rd", 32'(intf.mem_rd), 32'd0);
    chk("rst_addr", 32'(intf.mem_addr), 32'd0);
    run(3, 1'b0);
    chk("cold_instr", 32'(intf.instr), 32'h1234);
    chk("cold_pc", 32'(intf.instr_pc), 32'h0);
    chk("cold_valid", 32'(intf.instr_valid), 32'd1);
    run(1, 1'b0);
    chk("cold_addr3", 32'(intf.mem_addr), 32'd3);
    run(1, 1'b0);
    chk("cold_rd_drop", 32'(intf.mem_rd), 32'd0);
    run(3, 1'b0);
    chk("cold_hold", 32'(intf.instr), 32'h1234);

    // Streaming with take held high
    do_reset(0);
    run(3, 1'b1);
    chk("strm_w0", 32'(intf.instr), 32'h1234);
    run(1, 1'b1);
    chk("strm_gap", 32'(intf.instr_valid), 32'd0);
    run(1, 1'b1);
    chk("strm_w1", 32'(intf.instr), 32'h5678);
    chk("strm_pc1", 32'(intf.instr_pc), 32'd2);
    run(2, 1'b1);
    chk("strm_pc2", 32'(intf.instr_pc), 32'd4);

    // Three wait states per byte
    do_reset(3);
    run(8, 1'b0);
    chk("wait_c8", 32'(intf.instr_valid), 32'd0);
    run(1, 1'b0);
    chk("wait_c9", 32'(intf.instr_valid), 32'd1);
    chk("wait_instr", 32'(intf.instr), 32'h1234);

    // Redirect while the high byte is outstanding
    do_reset(3);
    run(2, 1'b0);
    step(1'b0, 1'b1, 16'h0101, 1'b0);
    chk("redir_old_addr", 32'(intf.mem_addr), 32'd0);
    chk("redir_rd", 32'(intf.mem_rd), 32'd1);
    run(2, 1'b0);
    chk("redir_new_addr", 32'(intf.mem_addr), 32'h0100);
    wait_valid(20);
    chk("redir_pc", 32'(intf.instr_pc), 32'h0100);
    chk("redir_word", 32'(intf.instr), 32'({mem[256], mem[257]}));

    // pc_load with low-byte ack and take in the same cycle
    do_reset(0);
    run(4, 1'b0);
    step(1'b0, 1'b1, 16'h0200, 1'b1);
    chk("sim_flush", 32'(intf.instr_valid), 32'd0);
    chk("sim_addr", 32'(intf.mem_addr), 32'h0200);
    run(2, 1'b0);
    chk("sim_pc", 32'(intf.instr_pc), 32'h0200);

    // Address wrap
    step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    wait_valid(20);
    chk("wrap_pc0", 32'(intf.instr_pc), 32'hFFFE);
    chk("wrap_w0", 32'(intf.instr), 32'({mem[65534], mem[65535]}));
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    wait_valid(20);
    chk("wrap_pc1", 32'(intf.instr_pc), 32'h0000);
    chk("wrap_w1", 32'(intf.instr), 32'h1234);

    // Random traffic
    wmin = 0; wmax = 3;
    for (int i = 0; i < 4000; i++) begin
      logic        rr, pl, tk;
      logic [15:0] pi;
      rr = ($urandom % 300) == 0;
      pl = ($urandom % 16) == 0;
      pi = ($urandom % 4 == 0) ? 16'(16'hFFF8 + 16'($urandom % 8)) : 16'($urandom);
      tk = $urandom % 2 == 0;
      step(rr, pl, pi, tk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the microcoded control unit. Reads 16-bit big-endian instruction words from the 8-bit program memory bus one byte at a time through a request/acknowledge handshake, and holds them in a small prefetch queue. Presents the head word as `instr[15:0]` to the control unit. Handles program-counter redirects (jumps/calls) by flushing the queue and discarding any in-flight byte.

## Interface
- `ADDR_W`, 16: byte-address width.
- `DEPTH`, 2: prefetch queue entries; power of two, ≥ 2.

- `clk`  in  1  system clock; all state updates on rising edge.
- `r`  in  1  reset; synchronous, active-high.
- `mem_addr`  out  ADDR_W  byte address of current read; registered.
- `mem_rd`  out  1  read request; registered.
- `mem_rdata`  in  8  read byte; valid in the cycle `mem_ack`=1.
- `mem_ack`  in  1  read complete; may be high in the same cycle `mem_rd` first rises.
- `pc_load`  in  1  redirect fetch to `pc_in`.
- `pc_in`  in  ADDR_W  redirect target; bit 0 ignored (forced 0).
- `instr`  out  16  head queue word; 16'h0000 when empty.
- `instr_valid`  out  1  queue non-empty.
- `instr_take`  in  1  control unit consumes head word this cycle.
- `instr_pc`  out  ADDR_W  byte address of head word; 0 when empty.

## Operation
- Reset (`r`=1 at a rising edge): `fetch_ptr`=0, queue empty, state IDLE, `mem_rd`=0, `mem_addr`=0, `instr`=0, `instr_valid`=0, `instr_pc`=0. `r` overrides every other input.
- States:
  - IDLE → HI when the queue count < DEPTH, evaluated before this cycle's take. Sets `mem_rd`=1 and `mem_addr`=`fetch_ptr`.
  - HI: hold `mem_rd`/`mem_addr` stable until `mem_ack`. On ack, latch the byte as `instr[15:8]`, set `mem_addr`=`fetch_ptr`+1, go to LO with `mem_rd` still 1.
  - LO: on ack, push {hi, `mem_rdata`} and its address into the queue, and set `fetch_ptr`+=2 (mod 2^ADDR_W). If there is room after this cycle's push/take, go directly to HI at the new `fetch_ptr`. Otherwise go to IDLE with `mem_rd`=0.
  - DRAIN: entered on `pc_load` while in HI or LO with no ack in that cycle. Keeps `mem_rd` high at the old address until ack, drops the returned byte, then goes to HI at the new `fetch_ptr`.
- Memory rule: once `mem_rd` rises, address and request stay stable until `mem_ack`; a transaction is never abandoned.
- `pc_load`:
  - Clears the queue and sets `fetch_ptr`={`pc_in`[ADDR_W-1:1],0}.
  - Takes priority over `instr_take` and over a push in the same cycle; the word completed that cycle is dropped.
  - If ack coincides with `pc_load`, the byte is dropped and the next state is HI at the new address (no DRAIN).
  - From IDLE, next state is HI.
- Queue:
  - Circular, depth DEPTH.
  - Push and take in the same cycle leave the count unchanged.
  - `instr_take` while empty is ignored.
  - A push into a full queue cannot occur, because LO is entered only with a reserved slot.
- `fetch_ptr` wraps from 2^ADDR_W−2 to 0.

## Timing
- Zero-wait memory (ack the same cycle as the request): `pc_load` at cycle N → `mem_rd`=1, `mem_addr`=target at N+1 → low byte at N+2 → `instr_valid`=1 at N+3. Same 3-cycle latency after `r` deasserts.
- Sustained throughput: one word per 2 cycles with zero-wait memory; each wait state adds one cycle per byte.
- `instr`, `instr_valid`, `instr_pc` are registered. They update the cycle after a push, take, or flush.
- A word pushed at edge E is takeable starting in cycle E+1.

## Test plan
- **Reset/cold fetch:** memory bytes {0x12,0x34,0x56,0x78} at 0..3, zero-wait, `r` released at cycle 0 → `instr`=0x1234, `instr_pc`=0 at cycle 3. With no takes, queue fills to 2 and `mem_rd` drops to 0 after address 3.
- **Streaming:** `instr_take` held high → successive words 0x1234, 0x5678, … each valid for one cycle, every 2 cycles, `instr_pc` stepping 0, 2, 4.
- **Wait states:** `mem_ack` delayed 3 cycles per byte → `mem_addr`/`mem_rd` stable throughout; first `instr_valid` at cycle 9.
- **Redirect mid-byte:** `pc_load`=1, `pc_in`=0x0101 while in HI awaiting ack → old transaction completes and its byte is dropped. Next request is at 0x0100, and the queue stays empty until that word arrives.
- **Simultaneous events:** `pc_load` in the same cycle as the low-byte ack and `instr_take` → no stale word appears; first valid word is at the new target.
- **Wrap:** `pc_load` 0xFFFE → words from 0xFFFE then 0x0000.
